// File: rtl/butterfly_pkg.sv
// -----------------------------------------------------------------------------
// butterfly_pkg
//   Shared types and helpers for the butterfly output collector:
//     state_e   - collector FSM states (IDLE / RUN / DRAIN / DONE)
//     len_t     - 16-bit transfer length / beat counter type
//     calc_epc  - engines grouped into one downstream channel
//     calc_chw  - bit width of one downstream channel beat
// -----------------------------------------------------------------------------
package butterfly_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic [15:0] len_t;

    function automatic int calc_epc(input int num_engine, input int out_chnl);
        return num_engine / out_chnl;
    endfunction

    function automatic int calc_chw(input int num_engine, input int out_chnl,
                                    input int lanes, input int data_width);
        return calc_epc(num_engine, out_chnl) * lanes * data_width;
    endfunction

endpackage

// File: rtl/butterfly_sync_fifo.sv
// -----------------------------------------------------------------------------
// butterfly_sync_fifo
//   Single-clock FIFO with register-backed output (no fall-through: a word
//   written at cycle N is visible at N+1 at the earliest).
//   Ports:
//     clk, rst   - clock, synchronous active-high reset (empties the FIFO)
//     wr_en_i    - push request, ignored when full
//     wr_data_i  - push data [WIDTH]
//     rd_en_i    - pop request, ignored when empty
//     rd_data_o  - head word, forced to zero while empty
//     vld_o      - FIFO holds at least one word
//     count_o    - current occupancy (0..DEPTH)
//   DEPTH must be a power of two and at least 2 so the pointers wrap freely.
// -----------------------------------------------------------------------------
module butterfly_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     vld_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push;
    logic             pop;

    assign push = wr_en_i && (count_q != FULL_CNT);
    assign pop  = rd_en_i && (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; the empty-gate on rd_data_o keeps stale or
    // uninitialised words from ever reaching the output.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign vld_o     = (count_q != '0);
    assign rd_data_o = vld_o ? mem_q[rd_ptr_q] : '0;
    assign count_o   = count_q;

endmodule

// File: rtl/butterfly_dn_collector.sv
// -----------------------------------------------------------------------------
// butterfly_dn_collector
//   Gathers lockstep beats from NUM_ENGINE butterfly engines, regroups them
//   into OUT_CHNL downstream channels (EPC consecutive engines per channel)
//   and buffers each channel in its own FIFO. A shared up_rdy applies real
//   backpressure; beats are counted against a programmed length and each
//   transfer is framed with dn_last and a done pulse.
//
//   Ports:
//     clk, rst  - clock, synchronous active-high reset
//     start     - one-cycle pulse, latches length (IDLE only)
//     length    - beats per transfer
//     up_vld    - per-engine valid      up_dat - engine e at slice e, LSB first
//     up_rdy    - shared ready to all engines
//     dn_vld    - per-channel valid     dn_dat - channel c at slice c, LSB first
//     dn_last   - final beat of the transfer on channel c
//     dn_rdy    - per-channel ready
//     busy      - FSM not in IDLE
//     done      - one-cycle end-of-transfer pulse
//     misalign  - sticky partial-valid error, cleared by start or rst
//     stall_cnt - (BFLY_COLLECT_PERF_EN only) RUN cycles with |up_vld && !up_rdy
//
//   Optional feature macro: BFLY_COLLECT_PERF_EN.
//   NUM_ENGINE must be a multiple of OUT_CHNL; FIFO_DEPTH a power of two >= 2.
// -----------------------------------------------------------------------------
module butterfly_dn_collector
    import butterfly_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int NUM_ENGINE       = 32,
    parameter int LANES_PER_ENGINE = 4,
    parameter int OUT_CHNL         = 8,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic [15:0]                                       length,
    input  logic [NUM_ENGINE-1:0]                             up_vld,
    input  logic [NUM_ENGINE*LANES_PER_ENGINE*DATA_WIDTH-1:0] up_dat,
    output logic                                              up_rdy,
    output logic [OUT_CHNL-1:0]                               dn_vld,
    output logic [OUT_CHNL*calc_chw(NUM_ENGINE, OUT_CHNL, LANES_PER_ENGINE, DATA_WIDTH)-1:0] dn_dat,
    output logic [OUT_CHNL-1:0]                               dn_last,
    input  logic [OUT_CHNL-1:0]                               dn_rdy,
    output logic                                              busy,
    output logic                                              done,
`ifdef BFLY_COLLECT_PERF_EN
    output logic [31:0]                                       stall_cnt,
`endif
    output logic                                              misalign
);

    localparam int              CHW      = calc_chw(NUM_ENGINE, OUT_CHNL,
                                                    LANES_PER_ENGINE, DATA_WIDTH);
    localparam int              CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

    state_e             state_q;
    len_t               len_q;
    len_t               in_cnt_q;
    logic               misalign_q;
    len_t               out_cnt_q [OUT_CHNL];

    logic [CW-1:0]      fifo_cnt  [OUT_CHNL];
    logic [CHW:0]       fifo_rd   [OUT_CHNL];
    logic [OUT_CHNL-1:0] fifo_full;
    logic [OUT_CHNL-1:0] fifo_empty;

    logic               start_ok;
    logic               accept;
    logic               partial;
    logic               last_beat;
    logic               all_empty;

    always_comb begin
        fifo_full  = '0;
        fifo_empty = '0;
        for (int c = 0; c < OUT_CHNL; c++) begin
            fifo_full[c]  = (fifo_cnt[c] == FULL_CNT);
            fifo_empty[c] = (fifo_cnt[c] == '0);
        end
    end

    // Ready is deliberately conservative: a full FIFO blocks the shared
    // ready even if that channel is being popped in the same cycle.
    assign up_rdy    = (state_q == ST_RUN) && !(|fifo_full);
    assign accept    = up_rdy && (&up_vld);
    assign partial   = up_rdy && (|up_vld) && !(&up_vld);
    assign last_beat = (in_cnt_q == len_q - 16'd1);
    assign all_empty = &fifo_empty;
    assign start_ok  = (state_q == ST_IDLE) && start;

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign misalign = misalign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            in_cnt_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        len_q      <= length;
                        in_cnt_q   <= '0;
                        misalign_q <= 1'b0;
                        state_q    <= (length == 16'd0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        // in_cnt stops at len_q, so len_q = 65535 never wraps.
                        in_cnt_q <= in_cnt_q + 16'd1;
                        if (last_beat) state_q <= ST_DRAIN;
                    end
                    if (partial) misalign_q <= 1'b1;
                end
                ST_DRAIN: begin
                    if (all_empty) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Channel c owns engines c*EPC..c*EPC+EPC-1, which are contiguous in
    // up_dat, so its payload is simply the c-th CHW-wide slice.
    for (genvar c = 0; c < OUT_CHNL; c++) begin : g_chnl
        butterfly_sync_fifo #(
            .WIDTH (CHW + 1),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (accept),
            .wr_data_i ({last_beat, up_dat[c*CHW +: CHW]}),
            .rd_en_i   (dn_rdy[c]),
            .rd_data_o (fifo_rd[c]),
            .vld_o     (dn_vld[c]),
            .count_o   (fifo_cnt[c])
        );

        assign dn_dat[c*CHW +: CHW] = fifo_rd[c][CHW-1:0];
        assign dn_last[c]           = fifo_rd[c][CHW];

        // Debug-only beat counter per channel.
        always_ff @(posedge clk) begin
            if (rst) begin
                out_cnt_q[c] <= '0;
            end else if (start_ok) begin
                out_cnt_q[c] <= '0;
            end else if (dn_vld[c] && dn_rdy[c]) begin
                out_cnt_q[c] <= out_cnt_q[c] + 16'd1;
            end
        end

        a_out_cnt_le_len: assert property (
            @(posedge clk) disable iff (rst) (out_cnt_q[c] <= len_q)
        );
    end

`ifdef BFLY_COLLECT_PERF_EN
    logic [31:0] stall_cnt_q;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (start_ok) begin
            stall_cnt_q <= '0;
        end else if ((state_q == ST_RUN) && (|up_vld) && !up_rdy) begin
            stall_cnt_q <= sat_inc32(stall_cnt_q);
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_butterfly_dn_collector.sv
module tb_butterfly_dn_collector;

    localparam int DATA_WIDTH       = 16;
    localparam int NUM_ENGINE       = 32;
    localparam int LANES_PER_ENGINE = 4;
    localparam int OUT_CHNL         = 8;
    localparam int FIFO_DEPTH       = 4;
    localparam int EPC = NUM_ENGINE / OUT_CHNL;
    localparam int CHW = EPC * LANES_PER_ENGINE * DATA_WIDTH;
    localparam int UPW = NUM_ENGINE * LANES_PER_ENGINE * DATA_WIDTH;

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic [15:0]             length;
    logic [NUM_ENGINE-1:0]   up_vld;
    logic [UPW-1:0]          up_dat;
    logic                    up_rdy;
    logic [OUT_CHNL-1:0]     dn_vld;
    logic [OUT_CHNL*CHW-1:0] dn_dat;
    logic [OUT_CHNL-1:0]     dn_last;
    logic [OUT_CHNL-1:0]     dn_rdy;
    logic                    busy;
    logic                    done;
    logic                    misalign;
`ifdef BFLY_COLLECT_PERF_EN
    logic [31:0]             stall_cnt;
`endif

    butterfly_dn_collector #(
        .DATA_WIDTH       (DATA_WIDTH),
        .NUM_ENGINE       (NUM_ENGINE),
        .LANES_PER_ENGINE (LANES_PER_ENGINE),
        .OUT_CHNL         (OUT_CHNL),
        .FIFO_DEPTH       (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .length   (length),
        .up_vld   (up_vld),
        .up_dat   (up_dat),
        .up_rdy   (up_rdy),
        .dn_vld   (dn_vld),
        .dn_dat   (dn_dat),
        .dn_last  (dn_last),
        .dn_rdy   (dn_rdy),
        .busy     (busy),
        .done     (done),
`ifdef BFLY_COLLECT_PERF_EN
        .stall_cnt(stall_cnt),
`endif
        .misalign (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Scoreboard: expected {last, data} per channel, pushed on accept.
    logic [CHW:0] exp_q [OUT_CHNL][$];
    logic [CHW:0] held  [OUT_CHNL];
    bit           stalled [OUT_CHNL];
    int           pops  [OUT_CHNL];
    int len_cur, acc, done_seen, first_stall_acc, rdy_seen, dnvld_seen, loop_n;

    task automatic chk(input string tag, input logic [CHW:0] obs, input logic [CHW:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_dat();
        for (int i = 0; i < UPW / 32; i++) up_dat[i*32 +: 32] = $urandom();
    endtask

    task automatic clear_sb(input int len);
        len_cur = len; acc = 0; done_seen = 0; first_stall_acc = -1;
        rdy_seen = 0; dnvld_seen = 0; loop_n = 0;
        for (int c = 0; c < OUT_CHNL; c++) begin
            exp_q[c].delete(); stalled[c] = 1'b0; pops[c] = 0; held[c] = '0;
        end
    endtask

    // One clock: observe at negedge, then let the posedge happen.
    task automatic cycle();
        logic [CHW:0] cur;
        logic [CHW:0] e;
        logic         lb;
        @(negedge clk);
        if (up_rdy) rdy_seen++;
        if (dn_vld != '0) dnvld_seen++;
        if (done) done_seen++;
        if (busy && !up_rdy && up_vld != '0 && acc < len_cur && first_stall_acc < 0)
            first_stall_acc = acc;
        if (up_rdy && (&up_vld)) begin
            lb = (acc == len_cur - 1);
            for (int c = 0; c < OUT_CHNL; c++) exp_q[c].push_back({lb, up_dat[c*CHW +: CHW]});
            acc++;
        end
        for (int c = 0; c < OUT_CHNL; c++) begin
            cur = {dn_last[c], dn_dat[c*CHW +: CHW]};
            if (stalled[c] && dn_vld[c]) chk($sformatf("hold_ch%0d", c), cur, held[c]);
            stalled[c] = dn_vld[c] && !dn_rdy[c];
            held[c]    = cur;
            if (dn_vld[c] && dn_rdy[c]) begin
                chk($sformatf("pop_expected_ch%0d", c), (exp_q[c].size() != 0), 1);
                if (exp_q[c].size() != 0) begin
                    e = exp_q[c].pop_front();
                    chk($sformatf("data_ch%0d_beat%0d", c, pops[c]), cur, e);
                end
                pops[c]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input int len);
        length = 16'(len);
        start  = 1'b1;
        up_vld = '0;
        dn_rdy = '1;
        cycle();
        start  = 1'b0;
    endtask

    // Full transfer: optional partial-valid glitch at beat glitch_at and
    // optional dn_rdy hold on channel hold_ch for the first hold_len cycles.
    task automatic run(input int len, input int glitch_at, input int hold_ch,
                       input int hold_len, input int max_cyc);
        bit glitched = 1'b0;
        bit glitch_now;
        clear_sb(len);
        start_xfer(len);
        chk("busy_after_start", busy, 1);
        chk("misalign_cleared_by_start", misalign, 0);
        while (done_seen == 0 && loop_n < max_cyc) begin
            glitch_now = 1'b0;
            up_vld = (acc < len) ? '1 : '0;
            rand_dat();
            if (acc == glitch_at && !glitched && up_rdy) begin
                up_vld[5] = 1'b0;
                glitched = 1'b1;
                glitch_now = 1'b1;
            end
            dn_rdy = '1;
            if (hold_ch >= 0 && loop_n < hold_len) dn_rdy[hold_ch] = 1'b0;
            cycle();
            loop_n++;
            if (glitch_now) chk("misalign_set", misalign, 1);
        end
        up_vld = '0;
        chk("done_pulses", done_seen, 1);
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        for (int c = 0; c < OUT_CHNL; c++) begin
            chk($sformatf("beats_ch%0d", c), pops[c], len);
            chk($sformatf("leftover_ch%0d", c), exp_q[c].size(), 0);
        end
    endtask

    task automatic chk_reset_values(input string pfx);
        chk({pfx, "_up_rdy"},   up_rdy, 0);
        chk({pfx, "_dn_vld"},   dn_vld, 0);
        chk({pfx, "_dn_dat"},   (dn_dat != '0), 0);
        chk({pfx, "_dn_last"},  dn_last, 0);
        chk({pfx, "_busy"},     busy, 0);
        chk({pfx, "_done"},     done, 0);
        chk({pfx, "_misalign"}, misalign, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; length = '0;
        up_vld = '0; up_dat = '0; dn_rdy = '0;
        clear_sb(0);
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("reset");
        rst = 1'b0;

        // Basic transfer.
        run(4, -1, -1, 0, 40);

        // Partial valid on engine 5 at beat 2; misalign stays until next start.
        run(6, 2, -1, 0, 40);
        chk("misalign_sticky", misalign, 1);

        // Backpressure on channel 3 for 8 cycles.
        run(8, -1, 3, 8, 80);
        chk("stall_after_accepts", first_stall_acc, FIFO_DEPTH);
`ifdef BFLY_COLLECT_PERF_EN
        chk("stall_cnt", stall_cnt, 5);
`endif

        // Zero length.
        run(0, -1, -1, 0, 10);
        chk("len0_no_up_rdy", rdy_seen, 0);
        chk("len0_no_dn_vld", dnvld_seen, 0);
        chk("len0_done_latency", loop_n, 1);

        // Reset mid-transfer after 2 accepted beats.
        clear_sb(8);
        start_xfer(8);
        while (acc < 2 && loop_n < 20) begin
            up_vld = '1;
            rand_dat();
            cycle();
            loop_n++;
        end
        chk("two_beats_before_reset", acc, 2);
        rst = 1'b1;
        up_vld = '0;
        cycle();
        chk_reset_values("midreset");
        rst = 1'b0;
        run(3, -1, -1, 0, 40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
